// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-to-decode handshake bundle for the instruction queue
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   instruction_f;
  logic [31:0]   pc_f;
  logic          mem_valid_f;
  logic          full_f;
  logic          flush;
  logic          stall_d;
  logic [31:0]   instruction_d;
  logic [31:0]   pc_d;
  logic          valid_d;
  logic [CW-1:0] count;

  modport master (
    output instruction_f, pc_f, mem_valid_f, flush, stall_d,
    input  full_f, instruction_d, pc_d, valid_d, count
  );

  modport slave (
    input  instruction_f, pc_f, mem_valid_f, flush, stall_d,
    output full_f, instruction_d, pc_d, valid_d, count
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction FIFO between fetch and decode
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   storage [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          valid;
  logic          full;
  logic          push;
  logic          pop;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full queue still accepts a word when the head leaves in the same cycle.
  assign pop  = valid & ~bus.stall_d & ~bus.flush;
  assign push = bus.mem_valid_f & ~bus.flush & (~full | pop);

  assign bus.valid_d       = valid;
  assign bus.full_f        = full;
  assign bus.count         = count_q;
  assign bus.instruction_d = valid ? storage[rd_ptr][63:32] : NOP_INSTR;
  assign bus.pc_d          = valid ? storage[rd_ptr][31:0]  : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= wr_ptr;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) storage[wr_ptr] <= {bus.instruction_f, bus.pc_f};
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  a_ptr_count : assert property (@(posedge clk) disable iff (rst)
    (wr_ptr - rd_ptr) == count_q[PW-1:0]);
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for the fetch-to-decode instruction queue
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.mem_valid_f   = v;
    bus.pc_f          = pc;
    bus.instruction_f = ins;
  endtask

  // Expected word for each accepted push; the monitor retires one per decode handshake.
  task automatic expect_word(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({ins, pc});
  endtask

  always @(negedge clk) begin
    if (!rst && bus.valid_d && !bus.stall_d && !bus.flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h with empty scoreboard", bus.pc_d);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("head_pc", bus.pc_d, e[31:0]);
        check("head_instr", bus.instruction_d, e[63:32]);
      end
    end
  end

  initial begin
    bus.flush   = 1'b0;
    bus.stall_d = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(bus.valid_d), 32'd0);
    check("rst_instr", bus.instruction_d, NOP);
    check("rst_pc", bus.pc_d, 32'h0);
    check("rst_full", 32'(bus.full_f), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);

    // Streaming with decode never stalling
    drive(1'b1, 32'h0, 32'hA);
    expect_word(32'h0, 32'hA);
    #1;
    check("no_bypass_valid", 32'(bus.valid_d), 32'd0);
    check("no_bypass_instr", bus.instruction_d, NOP);
    tick();
    check("stream_valid_rise", 32'(bus.valid_d), 32'd1);
    check("stream_count0", 32'(bus.count), 32'd1);
    drive(1'b1, 32'h4, 32'hB);
    expect_word(32'h4, 32'hB);
    tick();
    check("stream_count1", 32'(bus.count), 32'd1);
    drive(1'b1, 32'h8, 32'hC);
    expect_word(32'h8, 32'hC);
    tick();
    check("stream_count2", 32'(bus.count), 32'd1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drain", 32'(bus.count), 32'd0);

    // Fill and back-pressure: fifth word must be dropped
    bus.stall_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i * 4), 32'h100 + 32'(i));
      if (i < 4) expect_word(32'(i * 4), 32'h100 + 32'(i));
      tick();
      if (i == 3) begin
        check("fill_full", 32'(bus.full_f), 32'd1);
        check("fill_count", 32'(bus.count), 32'd4);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    check("overflow_count", 32'(bus.count), 32'd4);
    check("overflow_head", bus.pc_d, 32'h0);
    bus.stall_d = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("fill_drain", 32'(bus.count), 32'd0);
    check("empty_full", 32'(bus.full_f), 32'd0);

    // Push while full with a simultaneous pop
    bus.stall_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h200 + 32'(i));
      expect_word(32'(i * 4), 32'h200 + 32'(i));
      tick();
    end
    bus.stall_d = 1'b0;
    drive(1'b1, 32'h10, 32'h210);
    expect_word(32'h10, 32'h210);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("fullpop_count", 32'(bus.count), 32'd4);
    check("fullpop_full", 32'(bus.full_f), 32'd1);
    check("fullpop_head", bus.pc_d, 32'h4);
    for (int i = 0; i < 4; i++) tick();
    check("fullpop_drain", 32'(bus.count), 32'd0);

    // Flush with a concurrent push
    bus.stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h20 + 32'(i * 4), 32'h300 + 32'(i));
      tick();
    end
    check("preflush_count", 32'(bus.count), 32'd3);
    bus.flush = 1'b1;
    drive(1'b1, 32'h40, 32'h340);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_valid", 32'(bus.valid_d), 32'd0);
    check("flush_instr", bus.instruction_d, NOP);
    drive(1'b1, 32'h80, 32'h380);
    expect_word(32'h80, 32'h380);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("postflush_head", bus.pc_d, 32'h80);
    check("postflush_count", 32'(bus.count), 32'd1);
    bus.stall_d = 1'b0;
    tick();

    // Continuous stream across several slot wraps
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 32'h400 + 32'(i));
      expect_word(32'h100 + 32'(i * 4), 32'h400 + 32'(i));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("wrap_drain", 32'(bus.count), 32'd0);

    // Mid-stream reset with two entries held
    bus.stall_d = 1'b1;
    drive(1'b1, 32'h500, 32'h500);
    tick();
    drive(1'b1, 32'h504, 32'h504);
    tick();
    check("prereset_count", 32'(bus.count), 32'd2);
    check("prereset_head", bus.pc_d, 32'h500);
    rst = 1'b1;
    drive(1'b1, 32'h508, 32'h508);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_valid", 32'(bus.valid_d), 32'd0);
    check("midrst_full", 32'(bus.full_f), 32'd0);
    check("midrst_pc", bus.pc_d, 32'h0);
    bus.stall_d = 1'b0;
    tick();
    tick();

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
